// File: rtl/day_trading_pkg.sv
// rtl/day_trading_pkg.sv - shared action codes, FSM states and saturating arithmetic for the trading engine
package day_trading_pkg;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        BUY  = 2'd1,
        SELL = 2'd2,
        HOLD = 2'd3
    } action_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_e;

    // Signed add clamped to the range of a w-bit two's-complement register.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

endpackage

// File: rtl/price_window.sv
// rtl/price_window.sv - circular price buffer; reads are indexed from the oldest entry
module price_window #(
    parameter int   PRICE_W = 5,
    parameter int   WINDOW  = 3,
    localparam int  PTR_W   = $clog2(WINDOW),
    localparam int  CNT_W   = $clog2(WINDOW + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [PRICE_W-1:0] wr_data,
    input  logic [PTR_W-1:0]   rd_idx_a,
    input  logic [PTR_W-1:0]   rd_idx_b,
    output logic [PRICE_W-1:0] rd_data_a,
    output logic [PRICE_W-1:0] rd_data_b,
    output logic [PRICE_W-1:0] newest,
    output logic               fill_on_wr
);
    localparam logic [PTR_W:0]   WIN_P = (PTR_W + 1)'(WINDOW);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(WINDOW);

    logic [PRICE_W-1:0] mem_q [WINDOW];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // Once full, the write pointer addresses the oldest entry.
    function automatic logic [PTR_W-1:0] phys(input logic [PTR_W-1:0] base,
                                              input logic [PTR_W-1:0] idx);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + {1'b0, idx};
        if (sum >= WIN_P) sum = sum - WIN_P;
        return sum[PTR_W-1:0];
    endfunction

    assign rd_data_a  = mem_q[phys(wr_ptr_q, rd_idx_a)];
    assign rd_data_b  = mem_q[phys(wr_ptr_q, rd_idx_b)];
    assign newest     = mem_q[phys(wr_ptr_q, LAST)];
    assign fill_on_wr = (count_q >= FULL - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < WINDOW; i++) mem_q[i] <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
            wr_ptr_q        <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            if (count_q != FULL) count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/day_trading_engine.sv
// rtl/day_trading_engine.sv - windowed trend classifier emitting BUY/SELL/HOLD/WAIT with ownership and PnL
module day_trading_engine
    import day_trading_pkg::*;
#(
    parameter int PRICE_W    = 5,
    parameter int WINDOW     = 3,
    parameter int THRESH     = 0,
    parameter int PNL_W      = 16,
    parameter bit INIT_OWNED = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    price_valid,
    input  logic [PRICE_W-1:0]      price_in,
    output logic                    price_ready,
    output logic                    action_valid,
    output logic [1:0]              action,
    output logic                    owned,
    output logic signed [PNL_W-1:0] pnl,
    output logic [7:0]              trade_cnt
);
    localparam int               PTR_W     = $clog2(WINDOW);
    localparam logic [PTR_W-1:0] LAST_STEP = PTR_W'(WINDOW - 2);

    state_e                  state_q, state_d;
    logic                    ready_q;
    logic [PTR_W-1:0]        idx_q, idx_d;
    logic                    up_ok_q, up_ok_d, dn_ok_q, dn_ok_d;
    logic                    action_valid_q;
    action_e                 action_q, decision;
    logic                    owned_q;
    logic signed [PNL_W-1:0] pnl_q;
    logic [7:0]              trade_cnt_q;
    logic [PRICE_W-1:0]      buy_price_q;
    logic                    accept, emit, fill_on_wr;
    logic [PRICE_W-1:0]      p_old, p_new, newest;
    logic signed [PRICE_W:0] delta, gain;
    logic signed [31:0]      delta_ext;

    assign accept = price_valid && price_ready;

    price_window #(
        .PRICE_W (PRICE_W),
        .WINDOW  (WINDOW)
    ) u_window (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .wr_en      (accept && !flush),
        .wr_data    (price_in),
        .rd_idx_a   (idx_q),
        .rd_idx_b   (idx_q + 1'b1),
        .rd_data_a  (p_old),
        .rd_data_b  (p_new),
        .newest     (newest),
        .fill_on_wr (fill_on_wr)
    );

    assign delta     = $signed({1'b0, p_new}) - $signed({1'b0, p_old});
    assign delta_ext = {{(32 - PRICE_W - 1){delta[PRICE_W]}}, delta};
    assign gain      = $signed({1'b0, newest}) - $signed({1'b0, buy_price_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && fill_on_wr) state_d = SCAN;
                SCAN:    if (idx_q == LAST_STEP)   state_d = EMIT;
                EMIT:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        price_ready = ready_q && (state_q == IDLE);
        emit        = (state_q == EMIT) && !flush;
        if (up_ok_q)      decision = owned_q ? HOLD : BUY;
        else if (dn_ok_q) decision = owned_q ? SELL : WAIT;
        else              decision = owned_q ? HOLD : WAIT;
    end

    // Trend flags start optimistic and are knocked down by any step that fails the dead-band.
    always_comb begin
        idx_d   = '0;
        up_ok_d = 1'b1;
        dn_ok_d = 1'b1;
        if (state_q == SCAN) begin
            idx_d   = idx_q + 1'b1;
            up_ok_d = up_ok_q && (delta_ext > THRESH);
            dn_ok_d = dn_ok_q && (delta_ext < -THRESH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q        <= 1'b0;
            idx_q          <= '0;
            up_ok_q        <= 1'b1;
            dn_ok_q        <= 1'b1;
            action_valid_q <= 1'b0;
            action_q       <= WAIT;
            owned_q        <= INIT_OWNED;
            pnl_q          <= '0;
            trade_cnt_q    <= '0;
            buy_price_q    <= '0;
        end else begin
            ready_q        <= 1'b1;
            idx_q          <= idx_d;
            up_ok_q        <= up_ok_d;
            dn_ok_q        <= dn_ok_d;
            action_valid_q <= emit;
            if (emit) begin
                action_q <= decision;
                if (decision == BUY) begin
                    owned_q     <= 1'b1;
                    buy_price_q <= newest;
                    if (trade_cnt_q != 8'hFF) trade_cnt_q <= trade_cnt_q + 1'b1;
                end else if (decision == SELL) begin
                    owned_q <= 1'b0;
                    pnl_q   <= PNL_W'(sat_add(64'(pnl_q), 64'(gain), PNL_W));
                    if (trade_cnt_q != 8'hFF) trade_cnt_q <= trade_cnt_q + 1'b1;
                end
            end
        end
    end

    assign action_valid = action_valid_q;
    assign action       = action_q;
    assign owned        = owned_q;
    assign pnl          = pnl_q;
    assign trade_cnt    = trade_cnt_q;

endmodule

// File: tb/tb_day_trading_engine.sv
// tb/tb_day_trading_engine.sv - scoreboard bench for day_trading_engine across default, dead-band and narrow-PnL builds
module tb_day_trading_engine;
    import day_trading_pkg::*;

    localparam int W = 3;

    typedef struct packed {
        logic [1:0]  a;
        logic        o;
        logic [31:0] pnl;
        logic [7:0]  c;
        logic [31:0] at;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n, flush, price_valid;
    logic [4:0] price_in;
    logic r0, r1, r2, v0, v1, v2, o0, o1, o2;
    logic [1:0] a0, a1, a2;
    logic signed [15:0] p0, p1;
    logic signed [5:0] p2;
    logic [7:0] c0, c1, c2;
    int sel, cyc, n_vec, n_bad;
    logic m_ready, m_valid, m_owned;
    logic [1:0] m_action;
    logic [31:0] m_pnl;
    logic [7:0] m_cnt;
    ev_t exp_q[$];
    ev_t got_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    day_trading_engine u_base (
        .clk(clk), .rst_n(rst_n), .flush(flush), .price_valid(price_valid), .price_in(price_in),
        .price_ready(r0), .action_valid(v0), .action(a0), .owned(o0), .pnl(p0), .trade_cnt(c0));

    day_trading_engine #(.THRESH(1)) u_thresh (
        .clk(clk), .rst_n(rst_n), .flush(flush), .price_valid(price_valid), .price_in(price_in),
        .price_ready(r1), .action_valid(v1), .action(a1), .owned(o1), .pnl(p1), .trade_cnt(c1));

    day_trading_engine #(.PNL_W(6)) u_pnl6 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .price_valid(price_valid), .price_in(price_in),
        .price_ready(r2), .action_valid(v2), .action(a2), .owned(o2), .pnl(p2), .trade_cnt(c2));

    always_comb begin
        m_ready = r0; m_valid = v0; m_action = a0; m_owned = o0; m_pnl = 32'(p0); m_cnt = c0;
        if (sel == 1) begin
            m_ready = r1; m_valid = v1; m_action = a1; m_owned = o1; m_pnl = 32'(p1); m_cnt = c1;
        end else if (sel == 2) begin
            m_ready = r2; m_valid = v2; m_action = a2; m_owned = o2; m_pnl = 32'(p2); m_cnt = c2;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) got_q.delete();
        else if (m_valid) got_q.push_back({m_action, m_owned, m_pnl, m_cnt, 32'(cyc)});
    end

    task automatic do_reset();
        rst_n = 1'b1; flush = 1'b0; price_valid = 1'b0; price_in = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drive_price(input logic [4:0] p);
        int t = 0;
        @(negedge clk);
        price_valid = 1'b1; price_in = p;
        while (!m_ready && t < 20) begin @(negedge clk); t++; end
        n_vec++;
        if (!m_ready) begin n_bad++; $display("FAIL ready_timeout ready=%b required=1", m_ready); end
        @(posedge clk); #1;
        price_valid = 1'b0; price_in = 5'($urandom_range(0, 31));
    endtask

    task automatic send(input logic [4:0] p, input bit emit, input logic [1:0] a, input bit o,
                        input int pnl, input int c);
        drive_price(p);
        if (emit) exp_q.push_back({a, o, 32'(pnl), 8'(c), 32'(cyc + W)});
        repeat (W) @(posedge clk);
    endtask

    task automatic test_reset();
        sel = 0;
        rst_n = 1'b1; flush = 1'b0; price_valid = 1'b0; price_in = '0;
        #1 rst_n = 1'b0;
        #1 n_vec++;
        if ({m_ready, m_valid, m_action, m_owned, m_pnl, m_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got rdy=%b v=%b a=%0d o=%b pnl=%0d cnt=%0d required all 0",
                     m_ready, m_valid, m_action, m_owned, m_pnl, m_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        #1 n_vec++;
        if (m_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge got=%b required=0", m_ready); end
        @(posedge clk); #1 n_vec++;
        if (m_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset got=%b required=1", m_ready); end
    endtask

    task automatic test_flat();
        sel = 0; do_reset();
        send(5'd10, 0, WAIT, 0, 0, 0);
        send(5'd10, 0, WAIT, 0, 0, 0);
        send(5'd10, 1, WAIT, 0, 0, 0);
        @(negedge clk); #1 n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL flat_pulses got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            n_vec++;
            if (got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL flat_ev%0d got a=%0d o=%b pnl=%0d cnt=%0d t=%0d required a=%0d o=%b pnl=%0d cnt=%0d t=%0d",
                         k, got_q[k].a, got_q[k].o, $signed(got_q[k].pnl), got_q[k].c, got_q[k].at,
                         exp_q[k].a, exp_q[k].o, $signed(exp_q[k].pnl), exp_q[k].c, exp_q[k].at);
            end
        end
    endtask

    task automatic test_buy_hold_sell();
        sel = 0; do_reset();
        send(5'd5,  0, WAIT, 0, 0, 0);
        send(5'd10, 0, WAIT, 0, 0, 0);
        send(5'd15, 1, BUY,  1, 0, 1);
        send(5'd20, 1, HOLD, 1, 0, 1);
        send(5'd18, 1, HOLD, 1, 0, 1);
        send(5'd10, 1, SELL, 0, -5, 2);
        send(5'd5,  1, WAIT, 0, -5, 2);
        @(negedge clk); #1 n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL trade_pulses got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            n_vec++;
            if (got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL trade_ev%0d got a=%0d o=%b pnl=%0d cnt=%0d t=%0d required a=%0d o=%b pnl=%0d cnt=%0d t=%0d",
                         k, got_q[k].a, got_q[k].o, $signed(got_q[k].pnl), got_q[k].c, got_q[k].at,
                         exp_q[k].a, exp_q[k].o, $signed(exp_q[k].pnl), exp_q[k].c, exp_q[k].at);
            end
        end
    endtask

    task automatic test_thresh();
        sel = 1; do_reset();
        send(5'd7,  0, WAIT, 0, 0, 0);
        send(5'd8,  0, WAIT, 0, 0, 0);
        send(5'd9,  1, WAIT, 0, 0, 0);
        send(5'd12, 1, WAIT, 0, 0, 0);
        send(5'd15, 1, BUY,  1, 0, 1);
        @(negedge clk); #1 n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL thresh_pulses got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            n_vec++;
            if (got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL thresh_ev%0d got a=%0d o=%b pnl=%0d cnt=%0d t=%0d required a=%0d o=%b pnl=%0d cnt=%0d t=%0d",
                         k, got_q[k].a, got_q[k].o, $signed(got_q[k].pnl), got_q[k].c, got_q[k].at,
                         exp_q[k].a, exp_q[k].o, $signed(exp_q[k].pnl), exp_q[k].c, exp_q[k].at);
            end
        end
    endtask

    task automatic test_flush();
        sel = 0; do_reset();
        send(5'd5,  0, WAIT, 0, 0, 0);
        send(5'd10, 0, WAIT, 0, 0, 0);
        drive_price(5'd15);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk); n_vec++;
        if (m_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready got=%b required=1", m_ready); end
        n_vec++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b required=0", m_valid); end
        repeat (2) @(posedge clk);
        send(5'd20, 0, WAIT, 0, 0, 0);
        send(5'd25, 0, WAIT, 0, 0, 0);
        send(5'd30, 1, BUY,  1, 0, 1);
        @(negedge clk); #1 n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL flush_pulses got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            n_vec++;
            if (got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL flush_ev%0d got a=%0d o=%b pnl=%0d cnt=%0d t=%0d required a=%0d o=%b pnl=%0d cnt=%0d t=%0d",
                         k, got_q[k].a, got_q[k].o, $signed(got_q[k].pnl), got_q[k].c, got_q[k].at,
                         exp_q[k].a, exp_q[k].o, $signed(exp_q[k].pnl), exp_q[k].c, exp_q[k].at);
            end
        end
    endtask

    task automatic test_pnl_sat();
        logic [4:0] prices [6] = '{5'd0, 5'd1, 5'd2, 5'd31, 5'd30, 5'd29};
        int pe = 0;
        sel = 2; do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) begin
                logic [1:0] a;
                if (r == 3 && i == 3) break;
                if (i == 5) pe = (pe + 27 > 31) ? 31 : pe + 27;
                a = (i < 2) ? WAIT : (i == 2) ? BUY : (i == 5) ? SELL : HOLD;
                send(prices[i], !(r == 0 && i < 2), a, (i >= 2 && i <= 4), pe,
                     (i < 2) ? 2 * r : (i < 5) ? 2 * r + 1 : 2 * r + 2);
            end
        end
        @(negedge clk); #1 n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL sat_pulses got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            n_vec++;
            if (got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL sat_ev%0d got a=%0d o=%b pnl=%0d cnt=%0d t=%0d required a=%0d o=%b pnl=%0d cnt=%0d t=%0d",
                         k, got_q[k].a, got_q[k].o, $signed(got_q[k].pnl), got_q[k].c, got_q[k].at,
                         exp_q[k].a, exp_q[k].o, $signed(exp_q[k].pnl), exp_q[k].c, exp_q[k].at);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        drive_price(5'd31);
        n_vec++;
        if ({m_owned, m_pnl, m_cnt} !== {1'b1, 32'd31, 8'd7}) begin
            n_bad++;
            $display("FAIL pre_abort_state got o=%b pnl=%0d cnt=%0d required o=1 pnl=31 cnt=7", m_owned, m_pnl, m_cnt);
        end
        #2 rst_n = 1'b0;
        #1 n_vec++;
        if ({m_ready, m_valid, m_action, m_owned, m_pnl, m_cnt} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs got rdy=%b v=%b a=%0d o=%b pnl=%0d cnt=%0d required all 0",
                     m_ready, m_valid, m_action, m_owned, m_pnl, m_cnt);
        end
    endtask

    initial begin
        n_vec = 0; n_bad = 0; sel = 0;
        test_reset();
        test_flat();
        test_buy_hold_sell();
        test_thresh();
        test_flush();
        test_pnl_sat();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/day_trading_engine.md
Name: day_trading_engine

Overview:
- Streaming, parametrised successor to the single-word day-trading FSM.
- Accepts one price per handshake and keeps a sliding window of the last WINDOW prices.
- Classifies the window trend (up / down / flat-or-mixed) with a configurable dead-band, then emits BUY / SELL / HOLD / WAIT.
- Tracks ownership and realised profit-and-loss internally; sits between the price feed and the order logic.

Parameters:
- PRICE_W, 5: unsigned price width in bits.
- WINDOW, 3: prices per trend decision; legal range 2..16.
- THRESH, 0: dead-band; a step counts as a move only if |delta| > THRESH.
- PNL_W, 16: signed PnL accumulator width; must be ≥ PRICE_W+2.
- INIT_OWNED, 0: ownership value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the price window and any scan in progress.
- price_valid  in  1  price_in is valid.
- price_in  in  PRICE_W  unsigned price.
- price_ready  out  1  engine can accept a price.
- action_valid  out  1  single-cycle pulse; action is valid.
- action  out  2  decision code (encoding in package).
- owned  out  1  current ownership.
- pnl  out  PNL_W  signed realised profit, saturating.
- trade_cnt  out  8  completed BUY+SELL count, saturating at 255.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, window count 0, price_ready 0, action_valid 0, action WAIT, owned INIT_OWNED, pnl 0, trade_cnt 0, buy_price 0. price_ready rises in the first cycle after rst_n deasserts.
- FSM states:
  - IDLE: price_ready=1. Price accepted on price_valid&&price_ready at a clock edge.
    - Price written to circular buffer, overwriting the oldest.
    - count saturates at WINDOW.
    - If count (after write) < WINDOW: stay IDLE, no action.
    - Else go to SCAN with idx=0, up_ok=1, dn_ok=1.
  - SCAN: price_ready=0. One step per cycle: delta = p[idx+1] − p[idx], signed PRICE_W+1, oldest to newest.
    - up_ok &= (delta > THRESH).
    - dn_ok &= (delta < −THRESH).
    - After WINDOW−1 steps go to EMIT.
  - EMIT: price_ready=0, action_valid=1 for exactly one cycle; then IDLE.
- Latency: action_valid is high WINDOW edges after the accepting edge. Throughput is one price per WINDOW+1 cycles.
- Decision, using the owned value at EMIT:
  - up & !owned → BUY
  - up & owned → HOLD
  - dn & owned → SELL
  - dn & !owned → WAIT
  - neither & owned → HOLD
  - neither & !owned → WAIT
- Updates registered on the EMIT edge:
  - BUY: owned←1, buy_price←newest price, trade_cnt+1.
  - SELL: owned←0, pnl←sat(pnl + newest − buy_price), trade_cnt+1.
  - action and owned hold their values until the next EMIT.
- PnL saturation: clamp to [−2^(PNL_W−1), 2^(PNL_W−1)−1]; never wraps.
- Flush:
  - From any state: next state IDLE, count←0, action_valid forced 0 that cycle (no action emitted).
  - owned, pnl, trade_cnt and buy_price are retained.
  - flush has priority over a same-cycle handshake; the price is dropped.
- Window slide: after each decision, the next accepted price alone triggers a new decision (count stays WINDOW).
- rst_n asserted mid-SCAN/EMIT aborts immediately; no partial update is visible.
- price_in need only be stable during the handshake cycle.

Decomposition:
- day_trading_pkg:
  - action encoding: WAIT=2'd0, BUY=2'd1, SELL=2'd2, HOLD=2'd3
  - FSM state enum IDLE/SCAN/EMIT
  - saturating-add function
- One sub-module, price_window: circular buffer of WINDOW×PRICE_W with write pointer, count, flush, and an indexed read relative to the oldest entry.

Test Plan (PRICE_W=5, WINDOW=3, THRESH=0, PNL_W=16 unless stated):
1. Reset; feed 10,10,10 → no action_valid after first two prices; after third, action=WAIT, owned=0, pulse exactly 3 edges after acceptance.
2. Reset; feed 5,10,15 → BUY, owned=1, trade_cnt=1. Feed 20 (window 10,15,20) → HOLD. Feed 18 (window 15,20,18) → HOLD.
3. Continue from 2; feed 10 (window 20,18,10) → SELL, owned=0, pnl=16'hFFFB (−5), trade_cnt=2. Feed 5 → WAIT.
4. THRESH=1; feed 7,8,9 → WAIT (deltas not >1). Then feed 12 (window 8,9,12) → WAIT (8→9 fails). Then 15 (window 9,12,15) → BUY.
5. Feed 5,10,15 and assert flush in the first SCAN cycle → no action_valid; price_ready=1 next cycle; feeding 20,25 yields no action; 30 → BUY.
6. PNL_W=6; repeat buy at 0 (0,1,2 rising) and sell at 31 (31,30,29 falling) → pnl saturates at 31 and never wraps. Assert rst_n low mid-SCAN → all outputs return to reset values immediately.
